// File: rtl/fdtd_pkg.sv
// fdtd_pkg: shared state encoding and default grid constants for the fdtd blocks
package fdtd_pkg;
    typedef enum logic [1:0] {IDLE, EZ_SWEEP, SRC, STEP_END} fdtd_state_t;
    localparam int GRID_SIZE_DEF = 200;
    localparam int SRC_POS_DEF = 100;
endpackage

// File: rtl/fdtd_calc_ctrl.sv
// fdtd_calc_ctrl: per-time-step issue sequencer, Ez sweep over all cells, then a hard-source load
module fdtd_calc_ctrl
    import fdtd_pkg::*;
#(
    parameter int GRID_SIZE = GRID_SIZE_DEF,
    parameter int SRC_POS = SRC_POS_DEF,
    parameter int STEP_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start_i,
    input  logic [STEP_WIDTH-1:0]        nsteps_i,
    input  logic                         abort_i,
    input  logic                         ready_i,
    output logic                         calc_Ez_en_o,
    output logic                         calc_src_en_o,
    output logic [$clog2(GRID_SIZE)-1:0] addr_o,
    output logic [STEP_WIDTH-1:0]        step_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int AW = $clog2(GRID_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(GRID_SIZE - 1);
    localparam logic [AW-1:0] SRC_ADDR = AW'(SRC_POS);

    fdtd_state_t state, state_n;
    logic [STEP_WIDTH-1:0] nsteps_q, nsteps_n, step_n;
    logic [AW-1:0] addr_n;
    logic ez_n, src_n, done_n;

    assign busy_o = state != IDLE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            nsteps_q <= '0;
            step_o <= '0;
            addr_o <= '0;
            calc_Ez_en_o <= 1'b0;
            calc_src_en_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state <= state_n;
            nsteps_q <= nsteps_n;
            step_o <= step_n;
            addr_o <= addr_n;
            calc_Ez_en_o <= ez_n;
            calc_src_en_o <= src_n;
            done_o <= done_n;
        end
    end

    // Outputs are computed for the next state so the issue appears as the state is entered
    always_comb begin
        state_n = state;
        nsteps_n = nsteps_q;
        step_n = step_o;
        addr_n = addr_o;
        ez_n = 1'b0;
        src_n = 1'b0;
        done_n = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && nsteps_i != '0) begin
                    state_n = EZ_SWEEP;
                    nsteps_n = nsteps_i;
                    step_n = '0;
                    addr_n = '0;
                    ez_n = 1'b1;
                end else if (start_i) begin
                    done_n = 1'b1;
                end
            end
            EZ_SWEEP: begin
                ez_n = !(ready_i && addr_o == LAST_ADDR);
                src_n = ready_i && addr_o == LAST_ADDR;
                state_n = src_n ? SRC : EZ_SWEEP;
                addr_n = !ready_i ? addr_o : (src_n ? SRC_ADDR : addr_o + AW'(1));
            end
            SRC: begin
                src_n = !ready_i;
                state_n = ready_i ? STEP_END : SRC;
            end
            STEP_END: begin
                if (step_o == nsteps_q - STEP_WIDTH'(1)) begin
                    state_n = IDLE;
                    done_n = 1'b1;
                end else begin
                    state_n = EZ_SWEEP;
                    step_n = step_o + STEP_WIDTH'(1);
                    addr_n = '0;
                    ez_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort_i) begin
            state_n = IDLE;
            ez_n = 1'b0;
            src_n = 1'b0;
            done_n = 1'b0;
        end
    end
endmodule
